vram_fill: RTL

Pixel-RAM write engine for the 640×480 frame buffer scanned out by the VGA controller. It accepts single-pixel and rectangle-fill commands from the CPU side over a valid/ready handshake. It drives the frame buffer's write port with one 8-bit RRRGGGBB pixel per cycle, in raster order, using the same row/column addressing the display side reads.

---
 rtl/vram_fill_if.sv | 24 ++
 rtl/vram_fill.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vram_fill_if.sv
// Command channel into the pixel-RAM write engine: valid/ready handshake
// carrying a single-pixel or rectangle-fill request.
interface vram_fill_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [8:0] cmd_row0;
    logic [8:0] cmd_row1;
    logic [9:0] cmd_col0;
    logic [9:0] cmd_col1;
    logic [7:0] cmd_color;

    // Command source (CPU side)
    modport master (
        output cmd_valid, cmd_op, cmd_row0, cmd_row1, cmd_col0, cmd_col1, cmd_color,
        input  cmd_ready
    );

    // Command sink (write engine)
    modport slave (
        input  cmd_valid, cmd_op, cmd_row0, cmd_row1, cmd_col0, cmd_col1, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/vram_fill.sv
// Pixel-RAM write engine for the 640x480 frame buffer. Accepts single-pixel
// and rectangle-fill commands and emits one RRRGGGBB pixel per clock in
// raster order (column inner loop). All outputs except cmd_ready are
// registered; wr_row/wr_col double as the scan counters.
module vram_fill #(
    parameter int unsigned H_PIXELS = 640,
    parameter int unsigned V_LINES  = 480
) (
    input  logic         clk,
    input  logic         rst,
    vram_fill_if.slave   cmd,
    output logic         wr_en,
    output logic [8:0]   wr_row,
    output logic [9:0]   wr_col,
    output logic [7:0]   wr_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state, state_n;

    // Latched rectangle bounds and colour for the command in progress
    logic [8:0] row0_q, row1_q, row0_n, row1_n;
    logic [9:0] col0_q, col1_q, col0_n, col1_n;
    logic [7:0] color_q, color_n;

    // Next values of the registered outputs
    logic       wr_en_n, busy_n, done_n, err_n;
    logic [8:0] wr_row_n;
    logic [9:0] wr_col_n;
    logic [7:0] wr_data_n;

    // Command decode helpers
    logic       xfer;
    logic       cmd_legal;
    logic       cmd_single;
    logic       last_pix;
    logic [8:0] adv_row;
    logic [9:0] adv_col;

    assign cmd.cmd_ready = (state == IDLE) && !rst;
    assign xfer          = cmd.cmd_valid && cmd.cmd_ready;

    // Legality check and single-pixel detection on the presented command
    always_comb begin
        cmd_legal  = ({1'b0, cmd.cmd_row0} < 10'(V_LINES)) &&
                     ({1'b0, cmd.cmd_col0} < 11'(H_PIXELS));
        cmd_single = 1'b1;
        if (cmd.cmd_op) begin
            cmd_legal  = cmd_legal &&
                         (cmd.cmd_row0 <= cmd.cmd_row1) &&
                         ({1'b0, cmd.cmd_row1} < 10'(V_LINES)) &&
                         (cmd.cmd_col0 <= cmd.cmd_col1) &&
                         ({1'b0, cmd.cmd_col1} < 11'(H_PIXELS));
            cmd_single = (cmd.cmd_row0 == cmd.cmd_row1) &&
                         (cmd.cmd_col0 == cmd.cmd_col1);
        end
    end

    // Raster advance: column is the inner loop, wrapping to col0 at col1
    always_comb begin
        last_pix = (wr_row == row1_q) && (wr_col == col1_q);
        if (wr_col == col1_q) begin
            adv_col = col0_q;
            adv_row = 9'(wr_row + 9'd1);
        end else begin
            adv_col = 10'(wr_col + 10'd1);
            adv_row = wr_row;
        end
    end

    // Next-state and next-output logic; outputs are registered one cycle later
    always_comb begin
        state_n   = state;
        row0_n    = row0_q;
        row1_n    = row1_q;
        col0_n    = col0_q;
        col1_n    = col1_q;
        color_n   = color_q;
        wr_en_n   = 1'b0;
        wr_row_n  = wr_row;
        wr_col_n  = wr_col;
        wr_data_n = wr_data;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (xfer) begin
                    if (cmd_legal) begin
                        row0_n  = cmd.cmd_row0;
                        col0_n  = cmd.cmd_col0;
                        row1_n  = cmd.cmd_op ? cmd.cmd_row1 : cmd.cmd_row0;
                        col1_n  = cmd.cmd_op ? cmd.cmd_col1 : cmd.cmd_col0;
                        color_n = cmd.cmd_color;
                        // First pixel is issued straight from the command fields
                        // so it appears the cycle after transfer.
                        state_n   = WRITE;
                        wr_en_n   = 1'b1;
                        wr_row_n  = cmd.cmd_row0;
                        wr_col_n  = cmd.cmd_col0;
                        wr_data_n = cmd.cmd_color;
                        busy_n    = 1'b1;
                        done_n    = cmd_single;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (last_pix) begin
                    state_n = IDLE;
                end else begin
                    wr_en_n   = 1'b1;
                    wr_row_n  = adv_row;
                    wr_col_n  = adv_col;
                    wr_data_n = color_q;
                    busy_n    = 1'b1;
                    // done is registered, so flag the pixel about to be emitted
                    done_n    = (adv_row == row1_q) && (adv_col == col1_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs and latched command fields
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            row0_q  <= '0;
            row1_q  <= '0;
            col0_q  <= '0;
            col1_q  <= '0;
            color_q <= '0;
        end else begin
            wr_en   <= wr_en_n;
            wr_row  <= wr_row_n;
            wr_col  <= wr_col_n;
            wr_data <= wr_data_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            row0_q  <= row0_n;
            row1_q  <= row1_n;
            col0_q  <= col0_n;
            col1_q  <= col1_n;
            color_q <= color_n;
        end
    end

endmodule
